// File: rtl/link_rx_sink.sv
// link_rx_sink: receive-side byte sink. Buffers strobed bytes from the link
// slave in a small FIFO, presents them over valid/ready, and groups accepted
// bytes into fixed-length frames with a mod-2^WIDTH checksum.
module link_rx_sink #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 4,
    parameter int FRAME_LEN = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       in_ready,
    output logic                       out_valid,
    output logic [WIDTH-1:0]           out_data,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic [WIDTH-1:0]           frame_sum,
    output logic                       frame_done,
    output logic                       overflow
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH+1);
    localparam int BW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

    typedef enum logic {
        COLLECT = 1'b0,
        DONE    = 1'b1
    } state_t;

    state_t            state, state_d;
    logic [WIDTH-1:0]  mem [DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [WIDTH-1:0]  acc;
    logic [WIDTH-1:0]  acc_sum;
    logic [BW-1:0]     byte_cnt;
    logic              full, empty, push, pop, drop, frame_last;

    assign full      = (count == CW'(DEPTH));
    assign empty     = (count == '0);
    assign in_ready  = !full;
    assign out_valid = !empty;
    assign out_data  = mem[rd_ptr];

    // A full FIFO rejects the incoming byte even if a pop frees a slot this cycle.
    assign push       = in_valid && !full;
    assign drop       = in_valid && full;
    assign pop        = out_valid && out_ready;
    assign acc_sum    = acc + in_data;
    assign frame_last = push && (byte_cnt == BW'(FRAME_LEN-1));

    // Frame state register.
    always_ff @(posedge clk) begin
        if (rst) state <= COLLECT;
        else     state <= state_d;
    end

    // Next-state and pulse decode; a push during DONE already starts the next frame.
    always_comb begin
        state_d    = COLLECT;
        frame_done = 1'b0;
        if (state == DONE) frame_done = 1'b1;
        if (frame_last)    state_d    = DONE;
    end

    // Storage array; contents are don't-care while empty, so no reset.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= in_data;
    end

    // Pointers, occupancy, frame accumulator and sticky overflow flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            acc       <= '0;
            byte_cnt  <= '0;
            frame_sum <= '0;
            overflow  <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (drop) overflow <= 1'b1;
            if (frame_last) begin
                frame_sum <= acc_sum;
                acc       <= '0;
                byte_cnt  <= '0;
            end else if (push) begin
                acc       <= acc_sum;
                byte_cnt  <= byte_cnt + BW'(1);
            end
        end
    end

endmodule

// File: tb/tb_link_rx_sink.sv
// Directed self-checking bench for link_rx_sink.
module tb_link_rx_sink;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_ready;
    logic [2:0] count;
    logic [7:0] frame_sum;
    logic       frame_done;
    logic       overflow;

    int unsigned tests  = 0;
    int unsigned errors = 0;
    logic        toggle_rdy = 1'b0;

    logic [7:0] popped[$];
    logic [7:0] sums[$];
    int unsigned max_count = 0;

    link_rx_sink #(.WIDTH(8), .DEPTH(4), .FRAME_LEN(4)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .count(count), .frame_sum(frame_sum), .frame_done(frame_done),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    // Record consumed bytes, frame completions and peak occupancy.
    always @(posedge clk) begin
        if (!rst) begin
            if (out_valid && out_ready) popped.push_back(out_data);
            if (frame_done) sums.push_back(frame_sum);
            if (int'(count) > max_count) max_count <= int'(count);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (toggle_rdy) out_ready = ~out_ready;
    endtask

    task automatic push(input logic [7:0] b);
        in_valid = 1'b1;
        in_data  = b;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic check_popped(input string tag, input logic [7:0] exp[$]);
        check({tag, "_len"}, popped.size(), exp.size());
        for (int i = 0; i < exp.size() && i < popped.size(); i++)
            check(tag, popped[i], exp[i]);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;

        // Reset state
        tick(); tick();
        check("rst_in_ready",   in_ready,   1);
        check("rst_count",      count,      0);
        check("rst_out_valid",  out_valid,  0);
        check("rst_frame_done", frame_done, 0);
        check("rst_frame_sum",  frame_sum,  0);
        check("rst_overflow",   overflow,   0);
        rst = 1'b0;

        // Frame A1..A4 on alternate cycles
        out_ready = 1'b1;
        popped.delete(); sums.delete();
        push(8'hA1); tick();
        check("a_first_valid", out_valid, 0);
        push(8'hA2); tick();
        push(8'hA3); tick();
        push(8'hA4);
        check("a_done", frame_done, 1);
        check("a_sum",  frame_sum,  8'h8A);
        tick();
        check("a_done_drop", frame_done, 0);
        tick(); tick();
        check_popped("a_order", '{8'hA1, 8'hA2, 8'hA3, 8'hA4});
        check("a_ndone",    sums.size(), 1);
        check("a_overflow", overflow, 0);

        // Checksum wrap, then a second frame back-to-back
        sums.delete();
        push(8'hFF); push(8'hFF); push(8'hFF); push(8'hFF);
        check("wrap_done", frame_done, 1);
        check("wrap_sum",  frame_sum,  8'hFC);
        push(8'h01); push(8'h02); push(8'h03); push(8'h04);
        check("f2_done", frame_done, 1);
        check("f2_sum",  frame_sum,  8'h0A);
        tick(); tick();
        check("f2_ndone", sums.size(), 2);

        // Overflow with consumer stalled
        out_ready = 1'b0;
        popped.delete(); sums.delete();
        push(8'h10); push(8'h11); push(8'h12); push(8'h13);
        check("ov_count4",   count,      4);
        check("ov_in_ready", in_ready,   0);
        check("ov_done13",   frame_done, 1);
        check("ov_sum13",    frame_sum,  8'h46);
        check("ov_pre",      overflow,   0);
        push(8'h14);
        check("ov_flag",      overflow, 1);
        check("ov_count_hold", count,   4);
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        check_popped("ov_drain", '{8'h10, 8'h11, 8'h12, 8'h13});
        check("ov_sticky",  overflow,    1);
        check("ov_count0",  count,       0);
        check("ov_ndone",   sums.size(), 1);

        // Pointer wrap with simultaneous push/pop; source honours in_ready
        do_reset();
        check("wr_overflow_clr", overflow, 0);
        popped.delete(); sums.delete();
        max_count  = 0;
        out_ready  = 1'b1;
        toggle_rdy = 1'b1;
        for (int b = 0; b < 10; b++) begin
            int unsigned waits = 0;
            while (!in_ready && waits < 20) begin
                tick();
                waits++;
            end
            if (waits >= 20) check("wr_wait_timeout", waits, 0);
            push(8'(b));
        end
        toggle_rdy = 1'b0;
        out_ready  = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        check_popped("wr_order", '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04,
                                   8'h05, 8'h06, 8'h07, 8'h08, 8'h09});
        check("wr_maxcount", max_count <= 4, 1);
        check("wr_overflow", overflow, 0);
        check("wr_ndone", sums.size(), 2);
        if (sums.size() == 2) begin
            check("wr_sum0", sums[0], 8'h06);
            check("wr_sum1", sums[1], 8'h16);
        end

        // Reset mid-frame discards buffered bytes and the partial frame
        do_reset();
        out_ready = 1'b0;
        popped.delete(); sums.delete();
        push(8'h05); push(8'h06);
        check("mr_count_pre", count, 2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mr_count",     count,     0);
        check("mr_out_valid", out_valid, 0);
        out_ready = 1'b1;
        push(8'h01); push(8'h02); push(8'h03); push(8'h04);
        check("mr_done", frame_done, 1);
        check("mr_sum",  frame_sum,  8'h0A);
        tick(); tick(); tick();
        check("mr_ndone", sums.size(), 1);
        check_popped("mr_order", '{8'h01, 8'h02, 8'h03, 8'h04});

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule

// File: doc/link_rx_sink.md
# link_rx_sink

Receive-side byte sink that sits directly downstream of the link slave in `link_top`. Each byte the slave captures from the 4-phase req/ack transfer arrives here as a one-cycle strobe. The block buffers bytes in a small FIFO and hands them to the consumer over a valid/ready interface. It also groups accepted bytes into fixed-length frames, producing a mod-256 checksum and a completion pulse per frame.

## Interface
- `WIDTH`, 8: byte width.
- `DEPTH`, 4: FIFO entries; power of two, at least 2.
- `FRAME_LEN`, 4: accepted bytes per frame; at least 1.
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  one-cycle strobe from slave: byte captured.
- `in_data`  in  WIDTH  byte from slave; valid while `in_valid`=1.
- `in_ready`  out  1  FIFO not full; informational, since the slave does not stall.
- `out_valid`  out  1  FIFO not empty.
- `out_data`  out  WIDTH  head-of-FIFO byte.
- `out_ready`  in  1  consumer takes head when `out_valid`=1.
- `count`  out  $clog2(DEPTH+1)  current FIFO occupancy.
- `frame_sum`  out  WIDTH  checksum of the last completed frame.
- `frame_done`  out  1  one-cycle pulse: a frame completed.
- `overflow`  out  1  sticky: a byte was dropped.

## Operation
- FIFO state: circular buffer `mem`, pointers `wr_ptr` and `rd_ptr` of log2(DEPTH) bits each, plus occupancy `count`.
  - Pointers wrap modulo DEPTH.
  - full = (count==DEPTH); empty = (count==0).
- Push: `in_valid` && !full.
  - Write `mem[wr_ptr]`, then wr_ptr+1.
- Drop: `in_valid` && full.
  - Byte discarded; `overflow` set to 1 and held until `rst`.
  - FIFO, pointers, checksum and frame counter unchanged.
- Pop: `out_valid` && `out_ready`, then rd_ptr+1.
- Push and pop in the same cycle:
  - Both occur and `count` is unchanged.
  - When full, the push is still rejected (no pass-through) even if a pop occurs; the byte is dropped and `overflow` sets.
- Output decodes:
  - `out_data` = `mem[rd_ptr]`, a combinational read of registered state.
  - `in_ready` = !full; `out_valid` = !empty.
- Frame FSM, counting accepted pushes only:
  - COLLECT: `byte_cnt` runs 0..FRAME_LEN-1; `acc` holds the running sum.
  - On each push: acc ← (acc + in_data) mod 2^WIDTH and byte_cnt+1.
  - On the push where byte_cnt==FRAME_LEN-1, go to DONE:
    - `frame_sum` ← (acc + in_data) mod 2^WIDTH
    - acc ← 0, byte_cnt ← 0
  - DONE lasts exactly one cycle and asserts `frame_done`, then returns to COLLECT.
  - A push arriving during DONE is counted as byte 0 of the next frame.
- Frame accounting is independent of pops; consumer back-pressure never affects checksums except through dropped bytes.
- Reset values:
  - count=0, pointers=0, `out_valid`=0, `in_ready`=1.
  - `frame_sum`=0, `frame_done`=0, `overflow`=0.
  - byte_cnt=0, acc=0, FSM=COLLECT.
  - `out_data` is don't-care while `out_valid`=0.
- Reset mid-operation: all buffered bytes and any partial frame are discarded; no `frame_done` is emitted for the partial frame.

## Timing
- Push at edge k: `out_valid`=1 and `count` updated after edge k.
  - If the FIFO was empty, `out_data` = that byte in the cycle following edge k.
- Pop at edge k: the next entry appears after edge k.
- `in_ready` and `overflow` update one edge after the causing event.
- Last byte of a frame accepted at edge k:
  - `frame_done`=1 and the new `frame_sum` are valid for the cycle after edge k.
  - `frame_done` drops after edge k+1.
- Maximum throughput: one push and one pop per cycle.

## Test plan
- Reset with `rst`=1 for 2 cycles → all outputs at reset values; `in_ready`=1, `count`=0.
- Frame A1,A2,A3,A4 strobed on alternate cycles with `out_ready`=1 → bytes appear in order on `out_data`.
  - `frame_done` pulses once, one cycle after A4 is accepted.
  - `frame_sum`=8A; `overflow`=0.
- Checksum wrap: FF,FF,FF,FF → `frame_sum`=FC.
  - Follow with 01,02,03,04 → second `frame_done` pulse and `frame_sum`=0A.
- Overflow with `out_ready`=0, pushing 10,11,12,13,14:
  - After the 4th byte: `count`=4 and `in_ready`=0.
  - 14 is dropped and `overflow`=1; `frame_done` fires on 13.
  - Then `out_ready`=1 → 10,11,12,13 drain in order, `overflow` stays 1, and `count` returns to 0.
- Pointer wrap and simultaneous push/pop: 10 bytes 00..09 pushed back-to-back while `out_ready` toggles each cycle.
  - Output sequence is exactly 00..09 with no loss.
  - `count` never exceeds DEPTH.
  - `frame_done` fires after 03 and after 07.
- Reset mid-frame: push 05,06, then assert `rst`, then push 01,02,03,04.
  - FIFO is empty right after reset.
  - Exactly one `frame_done` pulse, with `frame_sum`=0A.
